// File: rtl/f_pc_unit.sv
// Fetch-stage program counter: holds the fetch PC and picks the next one with fixed priority
// (exception, eret, stall, redirect, sequential). A redirect that lands during a stall is parked
// until the stall releases. Fetch address errors are flagged against an instruction-memory window.
module f_pc_unit #(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC   = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_VEC     = 32'h0000_4180,
  parameter logic [ADDR_W-1:0] IM_LO       = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] IM_HI       = 32'h0000_6FFF,
  parameter bit                ERET_BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redir_valid,
  input  logic [ADDR_W-1:0] redir_target,
  input  logic              req,
  input  logic              eret,
  input  logic [ADDR_W-1:0] epc,
  output logic [ADDR_W-1:0] pc,
  output logic              exc_adel,
  output logic              redir_pending
);

  localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_t_q, pend_t_d;

  // eret return target: with the bypass the epc instruction is already fetched this cycle,
  // so the register must move on to the one after it.
  logic [ADDR_W-1:0] eret_next;
  assign eret_next = ERET_BYPASS ? (epc + PcStep) : epc;

  // Next-state selection in fixed priority order.
  always_comb begin
    pc_d     = pc_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;
    if (req) begin
      pc_d     = EXC_VEC;
      pend_v_d = 1'b0;
    end else if (eret) begin
      pc_d     = eret_next;
      pend_v_d = 1'b0;
    end else if (stall) begin
      // Park the redirect; a later one in the same stall overwrites it.
      if (redir_valid) begin
        pend_v_d = 1'b1;
        pend_t_d = redir_target;
      end
    end else if (redir_valid) begin
      // A live redirect is younger than any parked one and wins.
      pc_d     = redir_target;
      pend_v_d = 1'b0;
    end else if (pend_v_q) begin
      pc_d     = pend_t_q;
      pend_v_d = 1'b0;
    end else begin
      pc_d     = pc_q + PcStep;
    end
  end

  // State register with synchronous reset; reset drops any parked redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_VEC;
      pend_v_q <= 1'b0;
      pend_t_q <= '0;
    end else begin
      pc_q     <= pc_d;
      pend_v_q <= pend_v_d;
      pend_t_q <= pend_t_d;
    end
  end

  // Fetch address output; an exception in the same cycle suppresses the eret bypass.
  always_comb begin
    pc = pc_q;
    if (ERET_BYPASS && eret && !req) begin
      pc = epc;
    end
  end

  // Address error on whatever is presented as the fetch address; low bits are never masked.
  always_comb begin
    exc_adel = 1'b0;
    if (pc[1:0] != 2'b00) begin
      exc_adel = 1'b1;
    end
    if ((pc < IM_LO) || (pc > IM_HI)) begin
      exc_adel = 1'b1;
    end
  end

  assign redir_pending = pend_v_q;

endmodule

// File: tb/tb_f_pc_unit.sv
// Bench for f_pc_unit: two instances (eret bypass on/off) share stimulus. A high-level model
// predicts the fetch address and pending flag each cycle; directed literals pin key points.
module tb_f_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redir_valid, req, eret;
  logic [31:0] redir_target, epc;
  logic [31:0] pc1, pc0;
  logic        adel1, adel0, pend1, pend0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  f_pc_unit #(.ERET_BYPASS(1'b1)) u_byp (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .req(req), .eret(eret), .epc(epc),
    .pc(pc1), .exc_adel(adel1), .redir_pending(pend1)
  );

  f_pc_unit #(.ERET_BYPASS(1'b0)) u_nobyp (
    .clk(clk), .reset(reset), .stall(stall), .redir_valid(redir_valid),
    .redir_target(redir_target), .req(req), .eret(eret), .epc(epc),
    .pc(pc0), .exc_adel(adel0), .redir_pending(pend0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFF);
  endfunction

  // Model: architectural PC for each variant plus the parked redirect.
  logic        m_valid = 1'b0;
  logic [31:0] m_pc1, m_pc0, m_tgt;
  logic        m_pend;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b1;
      m_pc1   <= 32'h3000;
      m_pc0   <= 32'h3000;
      m_pend  <= 1'b0;
      m_tgt   <= 32'h0;
    end else if (m_valid) begin
      if (req) begin
        m_pc1 <= 32'h4180; m_pc0 <= 32'h4180; m_pend <= 1'b0;
      end else if (eret) begin
        m_pc1 <= epc + 32'd4; m_pc0 <= epc; m_pend <= 1'b0;
      end else if (stall) begin
        if (redir_valid) begin
          m_pend <= 1'b1; m_tgt <= redir_target;
        end
      end else if (redir_valid) begin
        m_pc1 <= redir_target; m_pc0 <= redir_target; m_pend <= 1'b0;
      end else if (m_pend) begin
        m_pc1 <= m_tgt; m_pc0 <= m_tgt; m_pend <= 1'b0;
      end else begin
        m_pc1 <= m_pc1 + 32'd4; m_pc0 <= m_pc0 + 32'd4;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic [31:0] e1;
    if (m_valid) begin
      e1 = (eret && !req) ? epc : m_pc1;
      check("model_pc_byp", pc1, e1);
      check("model_pc_nobyp", pc0, m_pc0);
      check("model_adel_byp", {31'b0, adel1}, {31'b0, bad_addr(e1)});
      check("model_adel_nobyp", {31'b0, adel0}, {31'b0, bad_addr(m_pc0)});
      check("model_pend_byp", {31'b0, pend1}, {31'b0, m_pend});
      check("model_pend_nobyp", {31'b0, pend0}, {31'b0, m_pend});
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redir_valid = 1'b0; req = 1'b0; eret = 1'b0;
    redir_target = '0; epc = '0;
    step(); step();
    reset = 1'b0; #1;
    check("rst_pc", pc1, 32'h3000);
    check("rst_pc_nobyp", pc0, 32'h3000);
    check("rst_adel", {31'b0, adel1}, 32'h0);
    check("rst_pend", {31'b0, pend1}, 32'h0);
    step(); #1; check("seq_3004", pc1, 32'h3004);
    step(); #1; check("seq_3008", pc1, 32'h3008);
    step(); #1; check("seq_300c", pc1, 32'h300C);
    step();
    // Redirect during a two-cycle stall.
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3400; #1;
    check("pre_stall_pc", pc1, 32'h3010);
    step(); redir_valid = 1'b0; #1;
    check("stall_hold_pc", pc1, 32'h3010);
    check("stall_pend", {31'b0, pend1}, 32'h1);
    step(); stall = 1'b0; #1;
    check("stall_hold_pc2", pc1, 32'h3010);
    step(); #1;
    check("release_pc", pc1, 32'h3400);
    check("release_pend", {31'b0, pend1}, 32'h0);
    // Second redirect in one stall overwrites the first.
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3400;
    step(); redir_target = 32'h3800;
    step(); stall = 1'b0; redir_valid = 1'b0;
    step(); #1;
    check("overwrite_pc", pc1, 32'h3800);
    // Exception beats everything, including a parked redirect.
    redir_valid = 1'b1; redir_target = 32'h3020;
    step(); stall = 1'b1; redir_target = 32'h3500;
    step(); #1;
    check("pre_req_pend", {31'b0, pend1}, 32'h1);
    req = 1'b1; eret = 1'b1; epc = 32'h3050; redir_target = 32'h3600; #1;
    check("req_suppresses_bypass", pc1, 32'h3020);
    step(); req = 1'b0; stall = 1'b0; redir_valid = 1'b0; #1;
    check("req_pc_nobyp", pc0, 32'h4180);
    check("req_pend", {31'b0, pend1}, 32'h0);
    check("eret_bypass_same", pc1, 32'h3050);
    step(); eret = 1'b0; #1;
    check("eret_next_byp", pc1, 32'h3054);
    check("eret_next_nobyp", pc0, 32'h3050);
    step(); #1;
    check("eret_seq_byp", pc1, 32'h3058);
    check("eret_seq_nobyp", pc0, 32'h3054);
    // Address window edges.
    redir_valid = 1'b1; redir_target = 32'h3002;
    step(); #1;
    check("mis_pc", pc1, 32'h3002);
    check("mis_adel", {31'b0, adel1}, 32'h1);
    redir_target = 32'h2FFC;
    step(); #1;
    check("below_adel", {31'b0, adel1}, 32'h1);
    redir_target = 32'h6FFC;
    step(); redir_valid = 1'b0; #1;
    check("top_pc", pc1, 32'h6FFC);
    check("top_adel", {31'b0, adel1}, 32'h0);
    step(); #1;
    check("above_pc", pc1, 32'h7000);
    check("above_adel", {31'b0, adel1}, 32'h1);
    // Sequential wrap at the top of the address space.
    redir_valid = 1'b1; redir_target = 32'hFFFF_FFFC;
    step(); redir_valid = 1'b0; #1;
    check("wrap_pre", pc1, 32'hFFFF_FFFC);
    step(); #1;
    check("wrap_pc", pc1, 32'h0);
    check("wrap_adel", {31'b0, adel1}, 32'h1);
    // Reset discards a parked redirect.
    stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3100;
    step(); redir_valid = 1'b0; #1;
    check("rst_pend_before", {31'b0, pend1}, 32'h1);
    reset = 1'b1;
    step(); reset = 1'b0; stall = 1'b0; #1;
    check("rst_mid_pc", pc1, 32'h3000);
    check("rst_mid_pend", {31'b0, pend1}, 32'h0);
    step(); #1;
    check("rst_discard_pc", pc1, 32'h3004);
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
